// File: rtl/conv3x3_stream_engine.sv
// conv3x3_stream_engine: 3x3 stride-1 no-pad multi-channel conv over a raster
// pixel stream; two line buffers + 3x3 window per channel, one summed result
// per valid window, valid/ready on both sides.
// Ports: clk, rst_n (async, active-low); start (frame start, IDLE only);
//   in_valid/in_ready/in_data (CH*DW beat); weight (CH*9*DW taps, stable);
//   out_valid/out_ready/out_data (ACC_W signed); busy (RUN|DRAIN); done pulse.
// Build option: define CONV_RELU_EN to clamp negative results to zero.
module conv3x3_stream_engine #(
  parameter int DW = 16,
  parameter int CH = 2,
  parameter int IMG_W = 6,
  parameter int IMG_H = 6,
  localparam int ACC_W = 2*DW + $clog2(9*CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH*DW-1:0]      in_data,
  input  logic [CH*9*DW-1:0]    weight,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_data,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = 2*DW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t r_state;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  logic signed [DW-1:0] r_lb0 [CH][IMG_W];
  logic signed [DW-1:0] r_lb1 [CH][IMG_W];
  // window taps, index r*3+j, j=2 is the newest column
  logic signed [DW-1:0] r_win [CH][9];

  logic signed [DW-1:0] w_pix [CH];
  logic signed [DW-1:0] w_nw  [CH][9];
  logic signed [PW-1:0] w_prod [CH][9];
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_res;

  logic w_acc;
  logic w_pop;
  logic w_wvalid;
  logic w_last;
  logic w_eol;

  assign in_ready = (r_state == S_RUN) && (!out_valid || out_ready);
  assign w_acc    = in_valid && in_ready;
  assign w_pop    = out_valid && out_ready;
  assign w_wvalid = (r_row >= RW'(2)) && (r_col >= CW'(2));
  assign w_eol    = (r_col == CW'(IMG_W-1));
  assign w_last   = (r_row == RW'(IMG_H-1)) && w_eol;
  assign busy     = (r_state != S_IDLE);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    assign w_pix[c] = in_data[c*DW +: DW];

    // window as it will look after this beat's shift
    for (genvar r = 0; r < 3; r++) begin : g_row
      assign w_nw[c][r*3+0] = r_win[c][r*3+1];
      assign w_nw[c][r*3+1] = r_win[c][r*3+2];
    end
    assign w_nw[c][2] = r_lb1[c][r_col];
    assign w_nw[c][5] = r_lb0[c][r_col];
    assign w_nw[c][8] = w_pix[c];

    for (genvar k = 0; k < 9; k++) begin : g_tap
      logic signed [DW-1:0] w_wt;
      logic signed [PW-1:0] w_a;
      logic signed [PW-1:0] w_b;
      assign w_wt = weight[((c*9)+k)*DW +: DW];
      assign w_a  = {{DW{w_nw[c][k][DW-1]}}, w_nw[c][k]};
      assign w_b  = {{DW{w_wt[DW-1]}}, w_wt};
      assign w_prod[c][k] = w_a * w_b;
    end
  end

  always_comb begin
    w_sum = '0;
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < 9; k++) begin
        w_sum = w_sum +
          {{(ACC_W-PW){w_prod[c][k][PW-1]}}, w_prod[c][k]};
      end
    end
  end

`ifdef CONV_RELU_EN
  assign w_res = w_sum[ACC_W-1] ? '0 : w_sum;
`else
  assign w_res = w_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_col     <= '0;
      r_row     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_col   <= '0;
            r_row   <= '0;
          end
        end
        S_RUN: begin
          if (w_acc) begin
            if (w_last) begin
              r_state <= S_DRAIN;
              r_col   <= '0;
              r_row   <= '0;
            end else if (w_eol) begin
              r_col <= '0;
              r_row <= r_row + RW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (!out_valid || out_ready) begin
            done    <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // a load wins over a same-cycle pop
      if (w_acc && w_wvalid) begin
        out_data  <= w_res;
        out_valid <= 1'b1;
      end else if (w_pop) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        for (int x = 0; x < IMG_W; x++) begin
          r_lb0[c][x] <= '0;
          r_lb1[c][x] <= '0;
        end
        for (int k = 0; k < 9; k++) begin
          r_win[c][k] <= '0;
        end
      end
    end else if (w_acc) begin
      for (int c = 0; c < CH; c++) begin
        r_lb1[c][r_col] <= r_lb0[c][r_col];
        r_lb0[c][r_col] <= w_pix[c];
        for (int k = 0; k < 9; k++) begin
          r_win[c][k] <= w_nw[c][k];
        end
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// tb_conv3x3_stream_engine: randomized frames against a direct
// sliding-window convolution model of the whole image.
module tb_conv3x3_stream_engine;

  localparam int DW = 16;
  localparam int CH = 2;
  localparam int W = 6;
  localparam int H = 6;
  localparam int ACC_W = 2*DW + $clog2(9*CH);
  localparam int NB = W*H;
  localparam int NO = (W-2)*(H-2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, busy, done;
  logic [CH*DW-1:0] in_data = '0;
  logic [CH*9*DW-1:0] weight = '0;
  logic [ACC_W-1:0] out_data;

  conv3x3_stream_engine #(
    .DW(DW), .CH(CH), .IMG_W(W), .IMG_H(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .weight(weight),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  longint img [CH][NB];
  longint wt  [CH][9];
  longint exp_q [$];

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sx(input logic [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v;
    return longint'(s);
  endfunction

  function automatic longint rnd_s();
    logic signed [DW-1:0] v;
    v = DW'($urandom);
    return longint'(v);
  endfunction

  // plain sliding-window sum over the stored image
  task automatic build_model();
    longint s;
    exp_q.delete();
    for (int r = 2; r < H; r++) begin
      for (int c = 2; c < W; c++) begin
        s = 0;
        for (int ch = 0; ch < CH; ch++)
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              s += img[ch][(r-2+i)*W + (c-2+j)] * wt[ch][i*3+j];
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        exp_q.push_back(s);
      end
    end
    for (int ch = 0; ch < CH; ch++)
      for (int k = 0; k < 9; k++)
        weight[((ch*9)+k)*DW +: DW] = DW'(wt[ch][k]);
  endtask

  task automatic run_frame(input string nm, input int omode,
                           input bit gaps, input bit chk_first,
                           input bit mid_start, input int abort_at);
    int beat, k, cyc, done_cnt, last_pop, done_cyc;
    int busy_low, irdy_bad, first_beat, extra;
    bit first_seen, finished;
    build_model();
    beat = 0; k = 0; cyc = 0; done_cnt = 0; last_pop = -1;
    done_cyc = -1; busy_low = 0; irdy_bad = 0; first_beat = -1;
    extra = 0; first_seen = 0; finished = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!finished && cyc < 2000) begin
      case (omode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      in_valid = (beat < NB) && (!gaps || $urandom_range(0, 3) != 0);
      for (int ch = 0; ch < CH; ch++)
        in_data[ch*DW +: DW] = DW'(img[ch][(beat < NB) ? beat : 0]);
      start = mid_start && (beat == 10);
      @(negedge clk);
      if (!done && !busy) busy_low++;
      if (beat < NB && in_ready != (!out_valid || out_ready)) irdy_bad++;
      if (out_valid && !first_seen) begin
        first_seen = 1;
        first_beat = beat;
      end
      if (out_valid && out_ready) begin
        if (k < NO) check($sformatf("%s_out%0d", nm, k), sx(out_data),
                          exp_q[k]);
        else extra++;
        k++;
        last_pop = cyc;
      end
      if (in_valid && in_ready) beat++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        finished = 1;
      end
      if (abort_at >= 0 && beat == abort_at) break;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (abort_at >= 0) begin
      check({nm, "_abort_nodone"}, done_cnt, 0);
      return;
    end
    check({nm, "_done_seen"}, finished, 1);
    check({nm, "_count"}, k, NO);
    check({nm, "_extra"}, extra, 0);
    check({nm, "_done_lat"}, done_cyc - last_pop, 1);
    check({nm, "_busy"}, busy_low, 0);
    check({nm, "_in_ready"}, irdy_bad, 0);
    if (chk_first) check({nm, "_first"}, first_beat, 2*W+3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check({nm, "_done_once"}, done_cnt, 1);
  endtask

  task automatic fill_rand(input int lo, input int hi);
    for (int ch = 0; ch < CH; ch++)
      for (int i = 0; i < NB; i++)
        img[ch][i] = (hi > lo) ? longint'($urandom_range(hi, lo)) : rnd_s();
  endtask

  initial begin
    int bad;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ramp, centre tap only
    for (int ch = 0; ch < CH; ch++) begin
      for (int i = 0; i < NB; i++) img[ch][i] = ch*100 + i;
      for (int t = 0; t < 9; t++) wt[ch][t] = (t == 4) ? 1 : 0;
    end
    run_frame("ramp", 0, 0, 1, 0, -1);

    // all ones
    for (int ch = 0; ch < CH; ch++) begin
      for (int i = 0; i < NB; i++) img[ch][i] = 1;
      for (int t = 0; t < 9; t++) wt[ch][t] = 1;
    end
    run_frame("ones", 0, 0, 1, 0, -1);

    // full-range random, out_ready toggling
    fill_rand(0, 0);
    for (int ch = 0; ch < CH; ch++)
      for (int t = 0; t < 9; t++) wt[ch][t] = rnd_s();
    run_frame("toggle", 1, 0, 0, 0, -1);

    // in_valid in IDLE must not be accepted
    bad = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = CH*DW'($urandom);
      @(negedge clk);
      if (in_ready || out_valid || busy) bad++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("idle_no_accept", bad, 0);

    // random gaps, random backpressure, start pulsed mid-frame
    fill_rand(0, 0);
    for (int ch = 0; ch < CH; ch++)
      for (int t = 0; t < 9; t++) wt[ch][t] = rnd_s();
    run_frame("midstart", 2, 1, 0, 1, -1);

    // abort after 21 beats, then a fresh frame
    fill_rand(0, 0);
    run_frame("abort", 0, 0, 0, 0, 21);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    fill_rand(0, 0);
    for (int ch = 0; ch < CH; ch++)
      for (int t = 0; t < 9; t++) wt[ch][t] = rnd_s();
    run_frame("after_abort", 0, 0, 1, 0, -1);

    // negative centre tap on ch0, positive pixels
    fill_rand(1, 30000);
    for (int ch = 0; ch < CH; ch++)
      for (int t = 0; t < 9; t++) wt[ch][t] = (ch == 0 && t == 4) ? -1 : 0;
    run_frame("neg", 0, 0, 0, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv3x3_stream_engine.md
# conv3x3_stream_engine

Parametrised 3x3, stride-1, no-padding multi-channel convolution engine. Accepts a raster-order pixel stream with CH channels packed per beat. Holds two line buffers and a 3x3 window per channel, and emits one summed output per valid window position over a valid/ready handshake. It replaces the fixed 4-wide, 2-channel, non-backpressured conv control path, and sits between the activation stream source and the ofmap writeback.

## Interface
Parameters:
- DW, 16: signed pixel and weight width.
- CH, 2: input channels summed into one output; ≥1.
- IMG_W, 6: ifmap width in pixels; ≥3.
- IMG_H, 6: ifmap height in rows; ≥3.
- Derived localparam ACC_W = 2*DW + $clog2(9*CH): output width, signed.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle frame start; sampled only in IDLE.
- in_valid  in  1  pixel beat valid.
- in_ready  out  1  engine can accept a beat.
- in_data  in  CH*DW  channel c at [c*DW +: DW].
- weight  in  CH*9*DW  tap (c,r,j) at [((c*9)+r*3+j)*DW +: DW]; r=0 is the top row, j=0 is the left column. Must be stable from start until done.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  ACC_W  signed convolution result.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at end of frame.

## Operation
- FSM states: IDLE, RUN, DRAIN. Reset state is IDLE.
- IDLE: in_ready=0. start moves the FSM to RUN and clears row/col counters. Line buffer contents are don't-care.
- RUN: in_ready = !out_valid | out_ready. A beat is accepted when in_valid & in_ready.
- Per accepted beat at (row, col):
  - lb1[col] <= lb0[col] and lb0[col] <= pixel, per channel.
  - Window shift registers shift left. The new right column is {lb1[col], lb0[col], pixel}, using the pre-update buffer values.
  - col increments. At col==IMG_W-1, col wraps to 0 and row increments.
- The window is valid when row≥2 and col≥2 at accept time. In that case, out_data <= Σ over c,r,j of win[c][r][j]*weight[c][r][j], computed at full signed precision with no truncation, and out_valid <= 1.
- out_valid clears on out_valid & out_ready unless a new result is loaded in the same cycle. A simultaneous load and pop loads the new result and keeps out_valid=1.
- Accepting the beat at (IMG_H-1, IMG_W-1) moves the FSM to DRAIN and drops in_ready.
- DRAIN: the FSM waits until out_valid==0 or the output pops that cycle, then pulses done and returns to IDLE.
- Output count per frame is (IMG_W-2)*(IMG_H-2), in raster order. No outputs are produced for column-0/1 or row-0/1 positions.
- start in RUN or DRAIN is ignored. in_valid in IDLE is ignored, with no accept.
- rst_n asserted mid-frame aborts the frame immediately. No done is issued, and the output is discarded.
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0. Counters, window registers and line buffers are reset to 0.

## Timing
- Latency: out_valid rises 1 cycle after the accept that completes a window.
- Throughput: 1 beat/cycle with out_ready held high.
- First output of a frame follows accepted beat index 2*IMG_W+2, counting from 0.
- done is asserted 1 cycle after the last output handshake, or 1 cycle after entering DRAIN if out_valid is already 0. The next start is accepted on the cycle after done.
- in_ready is combinational on out_valid and out_ready. There is no combinational path from in_valid to out_*.

## Configuration
- CONV_RELU_EN defined: any negative result is replaced by 0 before loading out_data.
- CONV_RELU_EN undefined: the signed sum is passed unchanged.
- No other behaviour differs between the two builds.

## Test plan
- Default params, in_data ramp (ch0 = index, ch1 = 100+index), weight = 1 at tap (c,1,1) only, out_ready=1 → 16 outputs; output k = (row+1)*6+(col+1) + 100 + same index; done pulses once, 1 cycle after the 16th output.
- All weights 1, all pixels 1 → every output = 18 (9*CH); exactly 16 outputs; first out_valid one cycle after beat 14 is accepted.
- out_ready toggling 1/0 every cycle with in_valid held high → in_ready low whenever out_valid=1 and out_ready=0; no output lost or duplicated; 16 outputs in raster order.
- start pulsed mid-RUN and in_valid driven in IDLE → no counter restart; no beats accepted in IDLE; busy stays high through the frame.
- rst_n dropped after beat 20, then a new start with a new frame → no done for the aborted frame; the new frame yields the correct 16 results.
- Center weight = -1 on ch0, other taps 0, pixels positive → with CONV_RELU_EN all outputs are 0; without it, outputs equal -pixel at full ACC_W sign extension.
